// File: rtl/game_input_pkg.sv
// game_input_pkg -- shared constants and types for the button conditioner.
//   Button indices into the 4-bit button vectors, the per-button debounce
//   state type, default timing constants and a counter width helper.
//   Used with and without BTN_AUTOREPEAT_EN.
package game_input_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_ROT   = 2;
  localparam int BTN_CLR   = 3;

  // 1 ms tick at 50 MHz; all other timing is expressed in ticks.
  localparam int TICK_DIV_DEF   = 50000;
  localparam int DEB_TICKS_DEF  = 20;
  localparam int RPT_DELAY_DEF  = 300;
  localparam int RPT_PERIOD_DEF = 100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DEB_ON  = 2'd1,
    ST_HELD    = 2'd2,
    ST_DEB_OFF = 2'd3
  } btn_state_e;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell -- debounce FSM (and optional auto-repeat) for one button.
//   Macro BTN_AUTOREPEAT_EN adds the repeat counters and RPT_* parameters;
//   without it move is the press pulse and no repeat logic exists.
// Ports:
//   CLK    in   system clock
//   RST    in   synchronous active-high reset
//   tick   in   one-cycle debounce/repeat time base
//   din    in   synchronized button bit
//   level  out  debounced level (registered)
//   press  out  one-cycle pulse on accepted press (registered)
//   move   out  press pulse plus auto-repeat pulses (registered)
//
// state      | meaning
// ST_IDLE    | released, waiting for a 1
// ST_DEB_ON  | saw a 1, counting stable ticks at 1
// ST_HELD    | accepted press, button held
// ST_DEB_OFF | saw a 0 while held, counting stable ticks at 0
module debounce_cell
  import game_input_pkg::*;
#(
  parameter int DEB_TICKS  = DEB_TICKS_DEF
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF,
  parameter bit RPT_EN     = 1'b1
`endif
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic press,
  output logic move
);

  localparam int SW = cnt_width(DEB_TICKS - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(DEB_TICKS - 1);

  btn_state_e    state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    press_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (din) begin
          state_d = ST_DEB_ON;
          stab_d  = '0;
        end
      end
      ST_DEB_ON: begin
        if (tick) begin
          if (!din) begin
            state_d = ST_IDLE;
            stab_d  = '0;
          end else if (stab_q == STAB_LAST) begin
            state_d = ST_HELD;
            stab_d  = '0;
            press_d = 1'b1;
          end else begin
            stab_d = stab_q + SW'(1);
          end
        end
      end
      ST_HELD: begin
        if (!din) begin
          state_d = ST_DEB_OFF;
          stab_d  = '0;
        end
      end
      ST_DEB_OFF: begin
        if (tick) begin
          if (din) begin
            state_d = ST_HELD;
            stab_d  = '0;
          end else if (stab_q == STAB_LAST) begin
            state_d = ST_IDLE;
            stab_d  = '0;
          end else begin
            stab_d = stab_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        stab_d  = '0;
      end
    endcase
    level_d = (state_d == ST_HELD) || (state_d == ST_DEB_OFF);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      stab_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAXV = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW = cnt_width(RPT_MAXV);
  localparam logic [RW-1:0] DELAY_V  = RW'(RPT_DELAY);
  localparam logic [RW-1:0] PERIOD_V = RW'(RPT_PERIOD);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;
  logic          rpt_armed_q, rpt_armed_d;  // first repeat already emitted
  logic          rpt_fire;
  logic          move_q, move_d;

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_fire    = 1'b0;
    rpt_inc     = (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + RW'(1);
    // Only ticks spent wholly inside HELD count; any exit restarts the delay.
    if (state_d != ST_HELD) begin
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
    end else if (RPT_EN && tick && (state_q == ST_HELD)) begin
      if (rpt_inc == (rpt_armed_q ? PERIOD_V : DELAY_V)) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_inc;
      end
    end
    move_d = press_d | rpt_fire;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
      move_q      <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
      move_q      <= move_d;
    end
  end

  assign move = move_q;
`else
  assign move = press_q;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner -- synchronizes, debounces and strobes four game buttons.
//   Holds the 2-flop synchronizers, the free-running tick generator and the
//   left/right move interlock; one debounce_cell per button.
//   Optional macro BTN_AUTOREPEAT_EN enables auto-repeat on left/right/rotate.
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   btn_raw    in   [3:0] raw switches {clear, rotation, right, left}
//   btn_level  out  [3:0] debounced levels
//   btn_press  out  [3:0] one-cycle press pulses
//   btn_move   out  [3:0] press plus repeat strobes, left/right interlocked
//   any_press  out  OR of btn_press
module btn_conditioner
  import game_input_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEB_TICKS  = DEB_TICKS_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_move,
  output logic       any_press
);

  if (TICK_DIV < 2 || DEB_TICKS < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_params
    $error("btn_conditioner: timing parameters out of range");
  end

  localparam int TW = cnt_width(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;
  logic [3:0]    cell_move;

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    tick_d     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_cell
    debounce_cell #(
      .DEB_TICKS (DEB_TICKS)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD),
      .RPT_EN    (i != BTN_CLR)
`endif
    ) u_cell (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick_q),
      .din  (sync2_q[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .move (cell_move[i])
    );
  end

  // Left and right together would cancel out, so neither moves.
  always_comb begin
    btn_move = cell_move;
    if (btn_level[BTN_LEFT] && btn_level[BTN_RIGHT]) begin
      btn_move[BTN_LEFT]  = 1'b0;
      btn_move[BTN_RIGHT] = 1'b0;
    end
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int TICK_DIV   = 4;
  localparam int DEB_TICKS  = 3;
  localparam int RPT_DELAY  = 5;
  localparam int RPT_PERIOD = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] btn_raw = 4'h0;
  logic [3:0] btn_level, btn_press, btn_move;
  logic       any_press;

  btn_conditioner #(
    .TICK_DIV  (TICK_DIV),
    .DEB_TICKS (DEB_TICKS),
    .RPT_DELAY (RPT_DELAY),
    .RPT_PERIOD(RPT_PERIOD)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_move (btn_move),
    .any_press(any_press)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a button's accepted level changes once the synced input
  // has disagreed with it on DEB_TICKS consecutive ticks; agreement on a tick
  // cancels the attempt. Repeats fire when the number of ticks spent held
  // reaches RPT_DELAY + k*RPT_PERIOD.
  int         m_edges;
  logic [3:0] m_h0, m_h1;
  bit         m_lvl[4], m_settle[4];
  int         m_run[4], m_held[4];
  logic [3:0] exp_level = 4'h0, exp_press = 4'h0, exp_move = 4'h0;

  always @(posedge CLK) begin
    bit t, s, was_held, rpt;
    logic [3:0] p, mv;
    if (RST) begin
      m_edges = 0;
      m_h0 = 4'h0;
      m_h1 = 4'h0;
      for (int i = 0; i < 4; i++) begin
        m_lvl[i] = 0; m_settle[i] = 0; m_run[i] = 0; m_held[i] = 0;
      end
      exp_level = 4'h0; exp_press = 4'h0; exp_move = 4'h0;
    end else begin
      m_edges++;
      t = (m_edges > 1) && (((m_edges - 1) % TICK_DIV) == 0);
      p = 4'h0;
      mv = 4'h0;
      for (int i = 0; i < 4; i++) begin
        s = m_h1[i];
        was_held = m_lvl[i] && !m_settle[i];
        rpt = 0;
        if (!m_settle[i]) begin
          if (s != m_lvl[i]) begin m_settle[i] = 1; m_run[i] = 0; end
        end else if (t) begin
          if (s == m_lvl[i]) m_settle[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == DEB_TICKS) begin
              m_lvl[i] = s; m_settle[i] = 0; p[i] = s;
            end
          end
        end
`ifdef BTN_AUTOREPEAT_EN
        if (i != 3) begin
          if (was_held && t && m_lvl[i] && !m_settle[i]) begin
            m_held[i]++;
            if (m_held[i] >= RPT_DELAY && ((m_held[i] - RPT_DELAY) % RPT_PERIOD) == 0) rpt = 1;
          end
          if (!(m_lvl[i] && !m_settle[i])) m_held[i] = 0;
        end
`endif
        exp_level[i] = m_lvl[i];
        mv[i] = p[i] | rpt;
      end
      if (exp_level[0] && exp_level[1]) mv[1:0] = 2'b00;
      exp_press = p;
      exp_move  = mv;
      m_h1 = m_h0;
      m_h0 = btn_raw;
    end
  end

  int cyc = 0;
  int press_cnt[4];
  int move_cnt[4];
  int press_cyc[4];
  int lr_move = 0;
  bit lr_phase = 0;
  int dur[4];
  int start, lat;
  logic [3:0] r;

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0; move_cnt[i] = 0; press_cyc[i] = 0;
    end
    lr_move = 0;
  endtask

  task automatic run_cycle(input logic [3:0] raw, input logic rst);
    btn_raw = raw;
    RST = rst;
    @(posedge CLK);
    #1;
    cyc++;
    check("level", btn_level, exp_level);
    check("press", btn_press, exp_press);
    check("move", btn_move, exp_move);
    check("any_press", any_press, |exp_press);
    for (int i = 0; i < 4; i++) begin
      if (btn_press[i]) begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (btn_move[i]) move_cnt[i]++;
    end
    if (lr_phase && press_cnt[1] > 0) lr_move += int'(btn_move[0]) + int'(btn_move[1]);
  endtask

  task automatic run_n(input int n, input logic [3:0] raw, input logic rst);
    for (int k = 0; k < n; k++) run_cycle(raw, rst);
  endtask

  initial begin
    clear_stats();
    // Reset state, with a button already pressed at the pins.
    run_n(3, 4'b0001, 1'b1);
    check("reset_outputs", {btn_level, btn_press, btn_move, any_press}, 13'h0);
    run_n(10, 4'h0, 1'b0);

    // Clean left press.
    clear_stats();
    start = cyc;
    run_n(40, 4'b0001, 1'b0);
    lat = press_cyc[0] - start;
    check("left_press_count", press_cnt[0], 1);
    check("left_latency_in_range", (lat >= 12 && lat <= 15), 1);
    check("left_level_held", btn_level[0], 1'b1);
    run_n(30, 4'h0, 1'b0);
    check("left_level_released", btn_level[0], 1'b0);
    check("left_no_extra_press", press_cnt[0], 1);

    // Rotation bouncing, then steady.
    clear_stats();
    for (int c = 0; c < 30; c++) run_cycle((((c / 3) % 2) == 0) ? 4'b0100 : 4'b0000, 1'b0);
    check("rot_no_press_while_bouncing", press_cnt[2], 0);
    run_n(40, 4'b0100, 1'b0);
    check("rot_one_press_after_steady", press_cnt[2], 1);
    run_n(30, 4'h0, 1'b0);

    // Right held long.
    clear_stats();
    run_n(80, 4'b0010, 1'b0);
    check("right_press_count", press_cnt[1], 1);
`ifdef BTN_AUTOREPEAT_EN
    check("right_repeats_seen", (move_cnt[1] >= 3), 1);
`else
    check("right_move_count", move_cnt[1], 1);
`endif
    run_n(30, 4'h0, 1'b0);

    // Clear held long: never repeats.
    clear_stats();
    run_n(80, 4'b1000, 1'b0);
    check("clear_press_count", press_cnt[3], 1);
    check("clear_move_count", move_cnt[3], 1);
    run_n(30, 4'h0, 1'b0);

    // Left held, then right: press fires, moves blocked.
    run_n(30, 4'b0001, 1'b0);
    clear_stats();
    lr_phase = 1;
    run_n(40, 4'b0011, 1'b0);
    lr_phase = 0;
    check("lr_right_press", press_cnt[1], 1);
    check("lr_moves_blocked", lr_move, 0);
    run_n(30, 4'h0, 1'b0);

    // Reset during debounce with left held through it.
    clear_stats();
    run_n(6, 4'b0001, 1'b0);
    run_n(2, 4'b0001, 1'b1);
    check("rst_abort_no_press", press_cnt[0], 0);
    start = cyc;
    run_n(30, 4'b0001, 1'b0);
    lat = press_cyc[0] - start;
    check("rst_fresh_press", press_cnt[0], 1);
    check("rst_latency_in_range", (lat >= 12 && lat <= 15), 1);
    run_n(30, 4'h0, 1'b0);

    // Randomized hold/bounce patterns with occasional reset.
    r = 4'h0;
    for (int i = 0; i < 4; i++) dur[i] = 0;
    for (int c = 0; c < 900; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (dur[i] == 0) begin
          r[i] = ~r[i];
          dur[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : $urandom_range(10, 60);
        end else begin
          dur[i]--;
        end
      end
      run_cycle(r, ($urandom_range(0, 249) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning CLK cycles per debounce/repeat tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEB_TICKS, default 20, meaning consecutive stable ticks required to accept a level change.
REQ-003 SHALL have parameter RPT_DELAY, default 300, meaning ticks held before the first auto-repeat.
REQ-004 SHALL have parameter RPT_PERIOD, default 100, meaning ticks between subsequent auto-repeats.
REQ-005 SHALL have port CLK  input  1  system clock; one clock domain only.
REQ-006 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-007 SHALL have port btn_raw  input  4  raw switches {clear, rotation, right, left}, asynchronous, active-high.
REQ-008 SHALL have port btn_level  output  4  debounced button levels.
REQ-009 SHALL have port btn_press  output  4  one-CLK pulse per accepted press.
REQ-010 SHALL have port btn_move  output  4  one-CLK move strobe: press pulse plus auto-repeat pulses.
REQ-011 SHALL have port any_press  output  1  OR of btn_press, same cycle.

Function
REQ-012 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL hold a free-running tick counter 0..TICK_DIV-1 and emit a one-CLK tick when it wraps to 0.
REQ-014 SHALL run one FSM per button with states IDLE, DEB_ON, HELD and DEB_OFF.
REQ-015 Transitions: IDLE->DEB_ON when the synced bit is 1; DEB_ON->IDLE when the bit is 0 on any tick; DEB_ON->HELD after DEB_TICKS consecutive ticks at 1; HELD->DEB_OFF when the bit is 0; DEB_OFF->HELD when the bit is 1 on any tick; DEB_OFF->IDLE after DEB_TICKS consecutive ticks at 0.
REQ-016 SHALL clear the stability counter on every state entry and on any opposing sample.
REQ-017 SHALL set btn_level to 1 in HELD and DEB_OFF, and to 0 otherwise.
REQ-018 SHALL assert btn_press for exactly the CLK cycle in which DEB_ON->HELD is taken (registered output).
REQ-019 Latency from btn_raw rising to btn_press: 2 synchronizer cycles plus up to DEB_TICKS*TICK_DIV cycles.
REQ-020 SHALL assert btn_move[i] in the same cycle as btn_press[i], and additionally on auto-repeat events (REQ-027).
REQ-021 Left and right both at level 1: SHALL suppress btn_move[0] and btn_move[1] (btn_press is unaffected).
REQ-022 Repeat counters SHALL saturate rather than wrap; the tick counter SHALL wrap at TICK_DIV-1.
REQ-023 A release-then-press bounce shorter than DEB_TICKS SHALL produce no extra btn_press.

Reset
REQ-024 With RST=1 at a CLK edge: all FSMs SHALL go to IDLE, all counters and synchronizer flops SHALL clear, and btn_level, btn_press, btn_move and any_press SHALL all be 0.
REQ-025 A button held through the release of reset SHALL produce a fresh btn_press after debounce.
REQ-026 RST asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse emitted.

Configuration
REQ-027 With macro BTN_AUTOREPEAT_EN defined: in HELD, bits 0-2 SHALL emit btn_move after RPT_DELAY ticks, then every RPT_PERIOD ticks while held; bit 3 (clear) SHALL never repeat.
REQ-028 With BTN_AUTOREPEAT_EN undefined: btn_move SHALL equal btn_press (subject to REQ-021), and no repeat counters SHALL be synthesized.

Structure
REQ-029 Package game_input_pkg SHALL hold the button index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_ROT=2, BTN_CLR=3, the FSM state typedef, and the default tick constants.
REQ-030 SHALL instantiate sub-module debounce_cell once per button; the top level SHALL hold the tick generator, synchronizers and left/right interlock.

Verification (TICK_DIV=4, DEB_TICKS=3, RPT_DELAY=5, RPT_PERIOD=2)
REQ-031 Clean left press held 40 cycles -> exactly one btn_press[0] about 12-14 cycles after the edge; btn_level[0]=1 until debounced release.
REQ-032 Rotation bouncing 1/0 every 3 cycles for 30 cycles, then steady 1 -> exactly one btn_press[2], occurring only after the steady period.
REQ-033 BTN_AUTOREPEAT_EN defined, right held 80 cycles -> btn_move[1] at press, then 20 cycles later, then every 8 cycles; clear held for the same time -> exactly one btn_move[3].
REQ-034 Left held, then right pressed -> btn_press[1] fires; btn_move[0] and btn_move[1] stay 0 while both are held.
REQ-035 RST pulsed during DEB_ON with left held -> no pulse during reset; btn_press[0] about 14 cycles after RST falls.
REQ-036 BTN_AUTOREPEAT_EN undefined, any button held 100 cycles -> btn_move equals btn_press cycle-for-cycle.
